// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data access onto one memory port
// Data has priority; fetch is forced through after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_signed,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           starve_cnt;
    logic                    grant, grant_fetch, capture;
    logic                    l_fetch, l_we, l_signed;
    logic [ADDR_WIDTH-1:0]   l_addr;
    logic [DATA_WIDTH-1:0]   l_wdata, lane_wdata, load_ext;
    logic [1:0]              l_size;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;

    always_comb begin
        state_n     = state;
        grant       = 1'b0;
        grant_fetch = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant       = 1'b1;
                    grant_fetch = if_req && (!d_req || starve_cnt >= SW'(STARVE_MAX));
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (MEM_LATENCY <= 1) begin
                    capture = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    capture = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Store data is replicated into every lane so the memory only needs byte enables.
    always_comb begin
        case (d_size)
            2'd0:    lane_wdata = {4{d_wdata[7:0]}};
            2'd1:    lane_wdata = {2{d_wdata[15:0]}};
            default: lane_wdata = d_wdata;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{l_addr[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{l_addr[1], 4'b0000} +: 16];
        case (l_size)
            2'd0:    load_ext = {{24{l_signed & ld_byte[7]}}, ld_byte};
            2'd1:    load_ext = {{16{l_signed & ld_half[15]}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            l_fetch    <= 1'b0;
            l_we       <= 1'b0;
            l_signed   <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_size     <= 2'd0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                l_fetch <= grant_fetch;
                if (grant_fetch) begin
                    l_we       <= 1'b0;
                    l_signed   <= 1'b0;
                    l_addr     <= if_addr;
                    l_wdata    <= '0;
                    l_size     <= 2'd2;
                    starve_cnt <= '0;
                end else begin
                    l_we     <= d_we;
                    l_signed <= d_signed;
                    l_addr   <= d_addr;
                    l_wdata  <= lane_wdata;
                    l_size   <= d_size;
                    if (if_req)
                        starve_cnt <= starve_cnt + SW'(1);
                end
            end
            if (state == ISSUE)
                cnt <= CW'(MEM_LATENCY - 1);
            else if (state == WAIT)
                cnt <= cnt - CW'(1);
            if (capture) begin
                if (l_fetch)
                    if_rdata <= mem_rdata;
                else if (!l_we)
                    d_rdata <= load_ext;
            end
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & l_we;
    assign mem_addr  = mem_en ? l_addr : '0;
    assign mem_wdata = mem_en ? l_wdata : '0;
    assign mem_size  = mem_en ? l_size : 2'd0;
    assign if_ack    = (state == DONE) & l_fetch;
    assign d_ack     = (state == DONE) & ~l_fetch;
    assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int SMAX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [1:0]    d_size = 2'd0;
    logic          if_ack, d_ack, stall, mem_en, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_size;

    logic [31:0]   mem [0:255];
    int            vectors = 0, miscompares = 0, cyc = 0;

    typedef struct { logic [31:0] addr; logic [31:0] rdata; } if_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; logic [31:0] rdata; } d_exp_t;
    if_exp_t       if_q[$];
    d_exp_t        d_q[$];
    logic [31:0]   last_load = '0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_signed(d_signed), .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-only memory model, valid on the sample edge of a latency-1 access
    assign mem_rdata = mem_en ? mem[mem_addr[9:2]] : 32'h0BADF00D;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        case (size)
            2'd0: begin
                v = (word >> (8 * int'(addr[1:0]))) & 32'hFF;
                if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
            end
            2'd1: begin
                v = (word >> (addr[1] ? 16 : 0)) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] w, input logic [1:0] size);
        if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    task automatic fetch_req(input logic [31:0] addr);
        if_exp_t e;
        e.addr  = addr;
        e.rdata = mem[addr[9:2]];
        if_q.push_back(e);
        if_addr = addr;
        if_req  = 1'b1;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input logic sgn);
        d_exp_t e;
        e.we    = we;
        e.addr  = addr;
        e.size  = size;
        e.wdata = wdata_model(wd, size);
        if (!we) last_load = load_model(mem[addr[9:2]], addr, size, sgn);
        e.rdata = last_load;
        d_q.push_back(e);
        d_we = we; d_addr = addr; d_wdata = wd; d_size = size; d_signed = sgn;
        d_req = 1'b1;
    endtask

    task automatic wait_ack(input logic fetch, output int at);
        at = -1;
        for (int n = 0; n < 60 && at < 0; n++) begin
            @(negedge clk);
            if (fetch ? if_ack : d_ack) at = cyc;
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ack timeout: got none expected ack within 60 cycles", fetch ? "if" : "d");
        end
        @(posedge clk);
        #1;
        if (fetch) if_req = 1'b0;
        else d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        if_q.delete(); d_q.delete(); last_load = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_if(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            fetch_req($urandom_range(0, 1023) & ~32'h3);
            wait_ack(1'b1, t);
        end
    endtask

    task automatic drive_d(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            data_req(1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom,
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_ack(1'b0, t);
        end
    endtask

    // Monitor: grant order from the priority/starvation rules, fields and acks from the queues
    logic p_if = 1'b0, p_d = 1'b0, gv = 1'b0, gf = 1'b0, ef;
    int   gcyc = 0, s = 0;
    always @(negedge clk) begin
        if (rst) begin
            p_if = 1'b0; p_d = 1'b0; gv = 1'b0; s = 0;
        end else begin
            chk("stall", stall, (if_req && !if_ack) || (d_req && !d_ack));
            if (mem_en) begin
                chk("mem_en while busy", gv, 1'b0);
                chk("mem_en without request", p_if || p_d, 1'b1);
                ef = (p_if && p_d) ? (s >= SMAX) : p_if;
                if (ef) begin
                    if (if_q.size() == 0) chk("fetch queue empty at mem_en", 0, 1);
                    else begin
                        chk("fetch mem_addr", mem_addr, if_q[0].addr);
                        chk("fetch mem_we", mem_we, 1'b0);
                        chk("fetch mem_size", mem_size, 2'd2);
                    end
                    s = 0;
                end else begin
                    if (d_q.size() == 0) chk("data queue empty at mem_en", 0, 1);
                    else begin
                        chk("data mem_addr", mem_addr, d_q[0].addr);
                        chk("data mem_we", mem_we, d_q[0].we);
                        chk("data mem_size", mem_size, d_q[0].size);
                        if (d_q[0].we) chk("data mem_wdata", mem_wdata, d_q[0].wdata);
                    end
                    if (p_if) s++;
                end
                gf = ef; gv = 1'b1; gcyc = cyc;
            end
            if (if_ack || d_ack) begin
                chk("ack without access", gv, 1'b1);
                chk("ack latency", cyc - gcyc, LAT);
                chk("ack kind is fetch", if_ack, gf);
                chk("both acks", if_ack && d_ack, 1'b0);
                if (if_ack && if_q.size() > 0) begin
                    chk("if_rdata", if_rdata, if_q[0].rdata);
                    void'(if_q.pop_front());
                end
                if (d_ack && d_q.size() > 0) begin
                    chk("d_rdata", d_rdata, d_q[0].rdata);
                    void'(d_q.pop_front());
                end
                gv = 1'b0;
            end
            p_if = if_req;
            p_d  = d_req;
        end
    end

    initial begin
        int tf, td, c0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        do_reset();
        @(negedge clk);
        chk("rst mem_en", mem_en, 0);     chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0); chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_size", mem_size, 0); chk("rst if_ack", if_ack, 0);
        chk("rst d_ack", d_ack, 0);       chk("rst if_rdata", if_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);   chk("rst stall", stall, 0);

        do_reset();
        mem[8'h40] = 32'hDEADBEEF;
        fetch_req(32'h100);
        @(negedge clk); chk("t2 c0 mem_en", mem_en, 0);
        @(negedge clk); chk("t2 c1 mem_en", mem_en, 1); chk("t2 c1 mem_addr", mem_addr, 32'h100);
        @(negedge clk); chk("t2 c2 if_ack", if_ack, 1); chk("t2 c2 if_rdata", if_rdata, 32'hDEADBEEF);
        @(posedge clk); #1; if_req = 1'b0;

        fetch_req(32'h100);
        @(negedge clk);
        @(negedge clk); chk("t1 access in flight", mem_en, 1);
        #2;
        rst = 1'b1; if_req = 1'b0; if_q.delete(); d_q.delete(); last_load = '0;
        #1;
        chk("t1 rst mem_en", mem_en, 0);  chk("t1 rst mem_addr", mem_addr, 0);
        chk("t1 rst if_ack", if_ack, 0);  chk("t1 rst if_rdata", if_rdata, 0);
        chk("t1 rst stall", stall, 0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t1 no ack after rst", if_ack | d_ack, 0);
            chk("t1 no mem_en after rst", mem_en, 0);
        end

        do_reset();
        c0 = cyc;
        fetch_req(32'h44);
        data_req(1'b0, 32'h48, 32'h0, 2'd2, 1'b0);
        fork
            wait_ack(1'b1, tf);
            wait_ack(1'b0, td);
        join
        chk("t3 data ack cycle", td - c0, 2);
        chk("t3 fetch ack follows data ack", tf - td, 3);

        do_reset();
        fetch_req(32'h80);
        data_req(1'b0, 32'h84, 32'h0, 2'd0, 1'b1);
        wait_ack(1'b0, td);
        data_req(1'b1, 32'h88, $urandom, 2'd1, 1'b0);
        wait_ack(1'b0, td);
        data_req(1'b0, 32'h8C, 32'h0, 2'd2, 1'b0);
        fork
            wait_ack(1'b1, tf);
            wait_ack(1'b0, td);
        join
        chk("t4 fetch granted after 2 data grants", tf < td, 1);

        do_reset();
        mem[0] = 32'h80000000;
        data_req(1'b0, 32'h3, 32'h0, 2'd0, 1'b1);
        wait_ack(1'b0, td);
        chk("t5 signed byte load", d_rdata, 32'hFFFFFF80);
        data_req(1'b0, 32'h3, 32'h0, 2'd0, 1'b0);
        wait_ack(1'b0, td);
        chk("t5 unsigned byte load", d_rdata, 32'h00000080);

        data_req(1'b1, 32'h2, 32'h5A5A1234, 2'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6 mem_en", mem_en, 1);   chk("t6 mem_we", mem_we, 1);
        chk("t6 mem_wdata", mem_wdata, 32'h12341234);
        chk("t6 mem_size", mem_size, 2'd1);
        wait_ack(1'b0, td);
        chk("t6 d_rdata unchanged by store", d_rdata, 32'h00000080);

        do_reset();
        fork
            drive_if(150);
            drive_d(150);
        join
        repeat (4) @(negedge clk);
        chk("queues drained", if_q.size() + d_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1);
    end
endmodule
